gbuf_dma: RTL and testbench

GBUF_DMA -- requirements
Module: gbuf_dma

---
 rtl/gbuf_dma_if.sv | 28 ++
 rtl/gbuf_dma.sv | 159 +++++++++++++++
 tb/tb_gbuf_dma.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gbuf_dma_if.sv
// rtl/gbuf_dma_if.sv - host stream bundle for gbuf_dma
// Purpose: groups the host input stream (s_*) and the result stream (m_*).
// Ports (members):
//   s_valid_i, s_data_i  host -> dma input words (A words first, then B words)
//   s_ready_o            dma -> host, input beat accepted when high with s_valid_i
//   m_valid_o, m_data_o  dma -> host result words
//   m_ready_i            host -> dma, result beat taken when high with m_valid_o
// Modports: master = host side, slave = gbuf_dma side.
interface gbuf_dma_if #(
    parameter int WORD_WIDTH = 80
);
    logic                  s_valid_i;
    logic                  s_ready_o;
    logic [WORD_WIDTH-1:0] s_data_i;
    logic                  m_valid_o;
    logic                  m_ready_i;
    logic [WORD_WIDTH-1:0] m_data_o;

    modport master (
        output s_valid_i, s_data_i, m_ready_i,
        input  s_ready_o, m_valid_o, m_data_o
    );

    modport slave (
        input  s_valid_i, s_data_i, m_ready_i,
        output s_ready_o, m_valid_o, m_data_o
    );
endinterface

// File: rtl/gbuf_dma.sv
// rtl/gbuf_dma.sv - global buffer DMA: load A/B, kick the array, drain P
// Purpose: runs one job per cmd_start_i. Streams A then B words from the host
// into buffers A and B, pulses the array start, waits for it to finish, then
// reads buffer P and streams it back through a 2-entry output FIFO.
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   cmd_start_i, len*/base_addr*_i job request and its lengths/bases
//   busy_o, done_o                 job status
//   strm                           host streams (gbuf_dma_if slave)
//   ena_o/wea_o/addra_o/worda_o    buffer A write port
//   enb_o/web_o/addrb_o/wordb_o    buffer B write port
//   enp_o/wep_o/addrp_o, wordp_i   buffer P read port (1-cycle read latency)
//   tpu_start_o, tpu_valid_i       array start pulse / array finished
module gbuf_dma #(
    parameter int ADDR_WIDTH = 16,
    parameter int WORD_WIDTH = 80
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  cmd_start_i,
    input  logic [ADDR_WIDTH-1:0] lena_i,
    input  logic [ADDR_WIDTH-1:0] lenb_i,
    input  logic [ADDR_WIDTH-1:0] lenp_i,
    input  logic [ADDR_WIDTH-1:0] base_addra_i,
    input  logic [ADDR_WIDTH-1:0] base_addrb_i,
    input  logic [ADDR_WIDTH-1:0] base_addrp_i,
    output logic                  busy_o,
    output logic                  done_o,
    gbuf_dma_if.slave             strm,
    output logic                  ena_o,
    output logic                  wea_o,
    output logic [ADDR_WIDTH-1:0] addra_o,
    output logic [WORD_WIDTH-1:0] worda_o,
    output logic                  enb_o,
    output logic                  web_o,
    output logic [ADDR_WIDTH-1:0] addrb_o,
    output logic [WORD_WIDTH-1:0] wordb_o,
    output logic                  enp_o,
    output logic                  wep_o,
    output logic [ADDR_WIDTH-1:0] addrp_o,
    input  logic [WORD_WIDTH-1:0] wordp_i,
    output logic                  tpu_start_o,
    input  logic                  tpu_valid_i
);
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_A, S_LOAD_B, S_KICK, S_WAIT, S_DRAIN, S_DONE
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_len_a, r_len_b, r_len_p;
    logic [ADDR_WIDTH-1:0] r_base_a, r_base_b, r_base_p;
    logic [ADDR_WIDTH-1:0] r_idx;
    logic [WORD_WIDTH-1:0] r_fifo [2];
    logic                  r_wr_ptr, r_rd_ptr;
    logic [1:0]            r_count;
    logic                  r_inflight;

    logic                  w_ld_a, w_ld_b, w_beat_a, w_beat_b, w_last;
    logic                  w_pop, w_issue, w_drained;
    logic [1:0]            w_occ;
    logic                  w_tpu_start, w_done;

    // A zero-length load phase keeps s_ready_o low and falls straight through.
    assign w_ld_a   = (r_state == S_LOAD_A) && (r_len_a != '0);
    assign w_ld_b   = (r_state == S_LOAD_B) && (r_len_b != '0);
    assign w_beat_a = w_ld_a && strm.s_valid_i;
    assign w_beat_b = w_ld_b && strm.s_valid_i;
    assign w_last   = (r_idx + ADDR_WIDTH'(1)) == (w_ld_a ? r_len_a : r_len_b);

    // Occupancy counts the word leaving this cycle as gone, so a steady
    // m_ready_i keeps one read issued per cycle without exceeding 2 slots.
    assign w_pop     = (r_count != 2'd0) && strm.m_ready_i;
    assign w_occ     = r_count + {1'b0, r_inflight} - {1'b0, w_pop};
    assign w_issue   = (r_state == S_DRAIN) && (r_idx != r_len_p) && (w_occ < 2'd2);
    assign w_drained = (r_idx == r_len_p) && (r_count == 2'd0) && !r_inflight;

    always_comb begin
        w_state_nxt = r_state;
        w_tpu_start = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE:   if (cmd_start_i) w_state_nxt = S_LOAD_A;
            S_LOAD_A: if (!w_ld_a || (w_beat_a && w_last)) w_state_nxt = S_LOAD_B;
            S_LOAD_B: if (!w_ld_b || (w_beat_b && w_last)) w_state_nxt = S_KICK;
            S_KICK: begin
                w_tpu_start = 1'b1;
                w_state_nxt = S_WAIT;
            end
            S_WAIT:   if (tpu_valid_i) w_state_nxt = (r_len_p == '0) ? S_DONE : S_DRAIN;
            S_DRAIN:  if (w_drained) w_state_nxt = S_DONE;
            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= S_IDLE;
            r_len_a    <= '0;
            r_len_b    <= '0;
            r_len_p    <= '0;
            r_base_a   <= '0;
            r_base_b   <= '0;
            r_base_p   <= '0;
            r_idx      <= '0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_count    <= 2'd0;
            r_inflight <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && cmd_start_i) begin
                r_len_a  <= lena_i;
                r_len_b  <= lenb_i;
                r_len_p  <= lenp_i;
                r_base_a <= base_addra_i;
                r_base_b <= base_addrb_i;
                r_base_p <= base_addrp_i;
                r_idx    <= '0;
            end else if (w_beat_a || w_beat_b) begin
                // Index restarts at 0 for the next phase after the last beat.
                r_idx <= w_last ? '0 : r_idx + ADDR_WIDTH'(1);
            end else if (w_issue) begin
                r_idx <= r_idx + ADDR_WIDTH'(1);
            end
            r_inflight <= w_issue;
            if (r_inflight) r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)      r_rd_ptr <= ~r_rd_ptr;
            r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
        end
    end

    // FIFO storage needs no reset: r_count gates every use of it.
    always_ff @(posedge clk_i) begin
        if (r_inflight) r_fifo[r_wr_ptr] <= wordp_i;
    end

    assign busy_o         = (r_state != S_IDLE);
    assign done_o         = w_done;
    assign tpu_start_o    = w_tpu_start;
    assign strm.s_ready_o = w_ld_a || w_ld_b;
    assign strm.m_valid_o = (r_count != 2'd0);
    assign strm.m_data_o  = (r_count != 2'd0) ? r_fifo[r_rd_ptr] : '0;

    assign ena_o   = w_beat_a;
    assign wea_o   = w_beat_a;
    assign addra_o = w_beat_a ? r_base_a + r_idx : '0;
    assign worda_o = w_beat_a ? strm.s_data_i : '0;
    assign enb_o   = w_beat_b;
    assign web_o   = w_beat_b;
    assign addrb_o = w_beat_b ? r_base_b + r_idx : '0;
    assign wordb_o = w_beat_b ? strm.s_data_i : '0;
    assign enp_o   = w_issue;
    assign wep_o   = 1'b0;
    assign addrp_o = w_issue ? r_base_p + r_idx : '0;
endmodule

// File: tb/tb_gbuf_dma.sv
// tb/tb_gbuf_dma.sv - self-checking bench for gbuf_dma
module tb_gbuf_dma;
    localparam int AW = 16;
    localparam int WW = 80;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          cmd_start_i;
    logic [AW-1:0] lena_i, lenb_i, lenp_i, base_addra_i, base_addrb_i, base_addrp_i;
    logic          busy_o, done_o;
    logic          ena_o, wea_o, enb_o, web_o, enp_o, wep_o;
    logic [AW-1:0] addra_o, addrb_o, addrp_o;
    logic [WW-1:0] worda_o, wordb_o, wordp_i;
    logic          tpu_start_o, tpu_valid_i;

    always #5 clk_i = ~clk_i;

    gbuf_dma_if #(.WORD_WIDTH(WW)) strm ();

    gbuf_dma #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .cmd_start_i(cmd_start_i),
        .lena_i(lena_i), .lenb_i(lenb_i), .lenp_i(lenp_i),
        .base_addra_i(base_addra_i), .base_addrb_i(base_addrb_i), .base_addrp_i(base_addrp_i),
        .busy_o(busy_o), .done_o(done_o), .strm(strm),
        .ena_o(ena_o), .wea_o(wea_o), .addra_o(addra_o), .worda_o(worda_o),
        .enb_o(enb_o), .web_o(web_o), .addrb_o(addrb_o), .wordb_o(wordb_o),
        .enp_o(enp_o), .wep_o(wep_o), .addrp_o(addrp_o), .wordp_i(wordp_i),
        .tpu_start_o(tpu_start_o), .tpu_valid_i(tpu_valid_i)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [WW-1:0] data;
    } wr_t;

    int            vectors = 0;
    int            miscompares = 0;
    int            cyc = 0;
    bit            chk_en = 1'b0;
    bit            in_job = 1'b0;
    int            outstanding, n_start, n_done, first_m, last_m;
    bit            prev_stall;
    logic [WW-1:0] prev_data;
    wr_t           exp_a[$], exp_b[$];
    logic [AW-1:0] exp_p[$];
    logic [WW-1:0] exp_m[$];
    logic [AW-1:0] log_a[$], log_p[$];
    logic [WW-1:0] log_m[$];
    wr_t           ea;
    logic [AW-1:0] ep;
    logic [WW-1:0] em;

    // Buffer P content is a fixed function of the address.
    function automatic logic [WW-1:0] pfun(input logic [AW-1:0] a);
        return {a, ~a, a ^ 16'h5A5A, a + 16'h1111, 16'hC0DE};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk_i) wordp_i <= enp_o ? pfun(addrp_o) : WW'({$urandom, $urandom, $urandom});

    initial forever begin
        @(posedge clk_i);
        cyc++;
    end

    // Compare process: every observed buffer/stream event is matched in order
    // against the expectations built from the job description.
    initial forever begin
        @(negedge clk_i);
        if (chk_en) begin
            check("wep_zero", wep_o, 0);
            check("busy", busy_o, in_job);
            if (ena_o || wea_o) begin
                check("a_en_pair", {ena_o, wea_o}, 2'b11);
                if (exp_a.size() == 0) check("a_extra_write", ena_o, 0);
                else begin
                    ea = exp_a.pop_front();
                    check("a_addr", addra_o, ea.addr);
                    check("a_data", worda_o, ea.data);
                    log_a.push_back(addra_o);
                end
            end
            if (enb_o || web_o) begin
                check("b_en_pair", {enb_o, web_o}, 2'b11);
                if (exp_b.size() == 0) check("b_extra_write", enb_o, 0);
                else begin
                    ea = exp_b.pop_front();
                    check("b_addr", addrb_o, ea.addr);
                    check("b_data", wordb_o, ea.data);
                end
            end
            if (prev_stall) check("m_hold", {m_valid_now(), strm.m_data_o}, {1'b1, prev_data});
            if (enp_o) begin
                outstanding++;
                if (exp_p.size() == 0) check("p_extra_read", enp_o, 0);
                else begin
                    ep = exp_p.pop_front();
                    check("p_addr", addrp_o, ep);
                    log_p.push_back(addrp_o);
                end
            end
            if (strm.m_valid_o && strm.m_ready_i) begin
                outstanding--;
                if (exp_m.size() == 0) check("m_extra_beat", strm.m_valid_o, 0);
                else begin
                    em = exp_m.pop_front();
                    check("m_data", strm.m_data_o, em);
                    log_m.push_back(strm.m_data_o);
                end
                if (first_m < 0) first_m = cyc;
                last_m = cyc;
            end
            if (enp_o || strm.m_valid_o) check("outstanding_le2", outstanding <= 2, 1);
            prev_stall = strm.m_valid_o && !strm.m_ready_i;
            prev_data  = strm.m_data_o;
            if (tpu_start_o) n_start++;
            if (done_o) n_done++;
        end
    end

    function automatic logic m_valid_now();
        return strm.m_valid_o;
    endfunction

    task automatic clear_model();
        exp_a.delete(); exp_b.delete(); exp_p.delete(); exp_m.delete();
        log_a.delete(); log_p.delete(); log_m.delete();
        outstanding = 0; n_start = 0; n_done = 0; first_m = -1; last_m = -1;
        prev_stall = 1'b0;
    endtask

    // rmode: 0 ready always, 1 toggle, 2 random, 3 held low
    task automatic run_job(input int la, input int lb, input int lp,
                           input logic [AW-1:0] ba, input logic [AW-1:0] bb, input logic [AW-1:0] bp,
                           input int rmode, input bit srand, input bit inject, input bit rst_mid);
        logic [WW-1:0] hw[$];
        int  hp, tcnt, tv_cyc, d_cyc;
        bit  acc, dseen, inj_t, inj_c;
        clear_model();
        for (int i = 0; i < la + lb; i++) hw.push_back(WW'({$urandom, $urandom, $urandom}));
        for (int i = 0; i < la; i++) exp_a.push_back('{addr: ba + AW'(i), data: hw[i]});
        for (int i = 0; i < lb; i++) exp_b.push_back('{addr: bb + AW'(i), data: hw[la + i]});
        for (int i = 0; i < lp; i++) begin
            exp_p.push_back(bp + AW'(i));
            exp_m.push_back(pfun(bp + AW'(i)));
        end
        @(posedge clk_i); #1;
        lena_i = AW'(la); lenb_i = AW'(lb); lenp_i = AW'(lp);
        base_addra_i = ba; base_addrb_i = bb; base_addrp_i = bp;
        cmd_start_i = 1'b1;
        @(posedge clk_i); #1;
        cmd_start_i = 1'b0;
        in_job = 1'b1;
        hp = 0; tcnt = 0; tv_cyc = -100; d_cyc = -1;
        dseen = 1'b0; inj_t = 1'b0; inj_c = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            strm.s_valid_i = (hp < la + lb) && (!srand || $urandom_range(0, 1) == 1);
            strm.s_data_i  = (hp < la + lb) ? hw[hp] : WW'(0);
            case (rmode)
                0:       strm.m_ready_i = 1'b1;
                1:       strm.m_ready_i = c[0];
                2:       strm.m_ready_i = ($urandom_range(0, 1) == 1);
                default: strm.m_ready_i = 1'b0;
            endcase
            tpu_valid_i = 1'b0;
            cmd_start_i = 1'b0;
            if (tcnt > 0) begin
                tcnt--;
                if (tcnt == 0) begin
                    tpu_valid_i = 1'b1;
                    tv_cyc = cyc;
                end
            end
            if (inject && !inj_t && hp > 0 && hp < la) begin
                tpu_valid_i = 1'b1;
                inj_t = 1'b1;
            end
            if (inject && !inj_c && tcnt > 0) begin
                cmd_start_i = 1'b1;
                lenp_i = lenp_i + AW'(3);
                inj_c = 1'b1;
            end
            if (rst_mid && tv_cyc > 0 && cyc == tv_cyc + 5) begin
                chk_en = 1'b0;
                #2 rst_ni = 1'b0;
                #1;
                check("rst_outputs_zero", |{busy_o, done_o, strm.s_ready_o, strm.m_valid_o, strm.m_data_o,
                      ena_o, wea_o, addra_o, worda_o, enb_o, web_o, addrb_o, wordb_o,
                      enp_o, wep_o, addrp_o, tpu_start_o}, 0);
                check("rst_busy", busy_o, 0);
                strm.s_valid_i = 1'b0; strm.m_ready_i = 1'b0; tpu_valid_i = 1'b0;
                @(posedge clk_i); #1;
                rst_ni = 1'b1;
                in_job = 1'b0;
                clear_model();
                chk_en = 1'b1;
                return;
            end
            @(negedge clk_i);
            acc = strm.s_valid_i && strm.s_ready_o;
            if (tpu_start_o) tcnt = $urandom_range(2, 5);
            if (done_o) begin
                dseen = 1'b1;
                d_cyc = cyc;
            end
            @(posedge clk_i); #1;
            if (acc) hp++;
            if (dseen) break;
        end
        in_job = 1'b0;
        strm.s_valid_i = 1'b0; tpu_valid_i = 1'b0; cmd_start_i = 1'b0;
        check("job_done", dseen, 1);
        check("tpu_start_count", n_start, 1);
        check("done_count", n_done, 1);
        check("a_left", exp_a.size(), 0);
        check("b_left", exp_b.size(), 0);
        check("p_left", exp_p.size(), 0);
        check("m_left", exp_m.size(), 0);
        if (lp == 0) check("done_after_tpu", d_cyc - tv_cyc, 1);
        if (rmode == 0 && lp > 0) check("throughput", last_m - first_m, lp - 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        cmd_start_i = 1'b0; tpu_valid_i = 1'b0;
        lena_i = '0; lenb_i = '0; lenp_i = '0;
        base_addra_i = '0; base_addrb_i = '0; base_addrp_i = '0;
        strm.s_valid_i = 1'b0; strm.s_data_i = '0; strm.m_ready_i = 1'b0;
        clear_model();
        rst_ni = 1'b1;
        #1 rst_ni = 1'b0;
        #2;
        check("reset_outputs_zero", |{busy_o, done_o, strm.s_ready_o, strm.m_valid_o,
              ena_o, wea_o, enb_o, web_o, enp_o, wep_o, tpu_start_o}, 0);
        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        chk_en = 1'b1;
        @(negedge clk_i);
        check("idle_busy", busy_o, 0);
        check("idle_s_ready", strm.s_ready_o, 0);

        run_job(4, 4, 4, 16'h0010, 16'h0020, 16'h0030, 0, 1'b0, 1'b0, 1'b0);
        check("pin_a0", log_a[0], 16'h0010);
        check("pin_a3", log_a[3], 16'h0013);
        check("pin_p3", log_p[3], 16'h0033);
        check("pin_m0", log_m[0], 80'h0030_FFCF_5A6A_1141_C0DE);

        run_job(4, 4, 4, 16'h0010, 16'h0020, 16'h0030, 1, 1'b1, 1'b0, 1'b0);
        check("pin_toggle_m3", log_m[3], pfun(16'h0033));

        run_job(0, 0, 0, 16'h0100, 16'h0200, 16'h0300, 0, 1'b0, 1'b0, 1'b0);

        run_job(4, 2, 3, 16'hFFFE, 16'h0040, 16'hFFFF, 2, 1'b1, 1'b0, 1'b0);
        check("pin_wrap_a0", log_a[0], 16'hFFFE);
        check("pin_wrap_a1", log_a[1], 16'hFFFF);
        check("pin_wrap_a2", log_a[2], 16'h0000);
        check("pin_wrap_a3", log_a[3], 16'h0001);
        check("pin_wrap_p1", log_p[1], 16'h0000);

        run_job(2, 2, 6, 16'h0500, 16'h0600, 16'h0700, 3, 1'b0, 1'b0, 1'b1);
        @(negedge clk_i);
        check("post_rst_busy", busy_o, 0);
        check("post_rst_m_valid", strm.m_valid_o, 0);
        run_job(3, 3, 5, 16'h0800, 16'h0900, 16'h0A00, 0, 1'b0, 1'b0, 1'b0);

        run_job(5, 3, 4, 16'h0B00, 16'h0C00, 16'h0D00, 2, 1'b1, 1'b1, 1'b0);
        check("inject_m_count", log_m.size(), 4);

        for (int j = 0; j < 12; j++) begin
            run_job($urandom_range(0, 12), $urandom_range(0, 12), $urandom_range(0, 12),
                    AW'($urandom), AW'($urandom), AW'($urandom),
                    $urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
